accel_spi_reader: RTL
=====================

# accel_spi_reader

- Upstream feeder of the accelerometer display stage on the DE10-LITE.
- Configures the on-board ADXL345 over 4-wire SPI (mode 3).
- Periodically burst-reads DATAX0, DATAX1, DATAY0 and DATAY1, presents the four bytes as stable registers, and pulses `data_valid`.
- `data_valid` drives the display stage's `start_display` input.

## Interface

Parameters:
- `DATA_WIDTH`, `'d8`: width of each data byte.
- `CLK_DIV`, `'d25`: clk cycles per SCLK half-period. At 50 MHz this gives 1 MHz SCLK. Must be ≥ 2.
- `SAMPLE_PERIOD`, `'d500000`: clk cycles between read starts (100 Hz at 50 MHz). Must be > 84*CLK_DIV.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `spi_cs_n` out 1: chip select, active low.
- `spi_sclk` out 1: SPI clock, idles high.
- `spi_mosi` out 1: master data out.
- `spi_miso` in 1: slave data in.
- `datax0`, `datax1`, `datay0`, `datay1` out DATA_WIDTH each: last sample bytes.
- `data_valid` out 1: one-cycle pulse when all four bytes have updated.
- `init_done` out 1: high once the configuration writes have finished.
- `busy` out 1: high while `spi_cs_n` is low.

## Operation

- FSM states: `RESET_WAIT`, `CFG_FMT`, `CFG_RATE`, `CFG_PWR`, `IDLE`, `READ`.
- Configuration sequence: each write is a 16-bit transaction, MSB first, command byte then data byte.
  - `CFG_FMT`: 0x31 ← 0x04. JUSTIFY=1 (left-justified), ±2 g, 10-bit, 4-wire SPI.
  - `CFG_RATE`: 0x2C ← 0x0A (100 Hz).
  - `CFG_PWR`: 0x2D ← 0x08 (measure mode).
- `RESET_WAIT` holds for 2*CLK_DIV cycles after reset release, then moves to `CFG_FMT`.
- After `CFG_PWR` completes: `init_done` goes to 1 and the FSM enters `IDLE`. The sample timer is cleared there.
- Sample timer:
  - Free-running in `IDLE`/`READ`.
  - Wraps at SAMPLE_PERIOD-1 and raises a tick on the wrap.
  - Tick in `IDLE` → go to `READ`.
  - Tick while `READ` is active → hold one pending tick, serviced after the inter-transaction gap. Further ticks are dropped.
- `READ` transaction: command 0xF2 (R=1, MB=1, address 0x32), then 32 clocks shifting in 4 bytes, 40 bits total.
- Incoming bytes go to shadow registers. Outputs load from the shadows only at the end of the transaction, so downstream never sees a mixed sample.
- During the read phase, `spi_mosi` is 0.

## Timing

- Reset values: `spi_cs_n`=1, `spi_sclk`=1, `spi_mosi`=0, all data outputs 0, `data_valid`=0, `init_done`=0, `busy`=0.
- A transaction of N bits runs as follows:
  - `spi_cs_n` falls.
  - After CLK_DIV cycles, the first SCLK falling edge occurs.
  - Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - After the last rising edge, wait CLK_DIV cycles, then `spi_cs_n` rises.
  - Total `spi_cs_n` low time: (2N+2)*CLK_DIV cycles. Write = 34*CLK_DIV; read = 82*CLK_DIV.
- Bit edges:
  - MOSI changes on the registered SCLK falling edge, and for the first bit at the `spi_cs_n` fall.
  - MISO is sampled in the clk cycle where `spi_sclk` is driven high.
- Gap between transactions: `spi_cs_n` high for exactly 2*CLK_DIV cycles during configuration, and at least that long otherwise.
- End of a read: on the clk edge that drives `spi_cs_n` high, the data outputs load and `data_valid`=1 for exactly one cycle.
- `busy` equals the inverse of registered `spi_cs_n`.
- Reset asserted mid-transaction: on the next edge, all outputs return to their reset values and the shadow registers are discarded. Reset release restarts the full configuration.

## Structure

- Package `accel_pkg` holds:
  - Register addresses 0x31, 0x2C, 0x2D, 0x32.
  - Configuration values 0x04, 0x0A, 0x08.
  - Command bit positions: R=bit 7, MB=bit 6.
  - The FSM state enum.
- Sub-module `spi_shift_engine`:
  - Inputs: start, bit count (up to 40), 16-bit TX word.
  - Behaviour: generates CS/SCLK/MOSI, shifts MISO into a 32-bit RX register, and pulses done on CS rise.
- Top level holds the FSM, sample timer, shadow registers and output registers.

## Test plan

All tests use CLK_DIV=2, SAMPLE_PERIOD=400, and an SPI slave model.

- Reset release → MOSI byte stream is 0x31 0x04, 0x2C 0x0A, 0x2D 0x08.
  - Each write has `spi_cs_n` low for 68 cycles, with 4-cycle gaps between writes.
  - `init_done` rises at the end of the 0x2D write.
- First read: model returns 0x40, 0x12, 0xC0, 0xFE.
  - Command byte is 0xF2 and `spi_cs_n` is low for 164 cycles.
  - Result: `datax0`=0x40, `datax1`=0x12, `datay0`=0xC0, `datay1`=0xFE, with a single `data_valid` pulse coincident with the `spi_cs_n` rise.
- Periodicity: consecutive read starts are 400 cycles apart. Outputs are unchanged between `data_valid` pulses, even while shifting.
- SPI mode check:
  - `spi_sclk` is high whenever `spi_cs_n` is high.
  - MOSI is stable across every SCLK rising edge.
  - The model asserts no protocol violation.
- `rst_n` low at read bit 20 → next cycle has `spi_cs_n`=1, all data outputs 0, `init_done`=0. After release, the configuration sequence repeats in full.
- SAMPLE_PERIOD=150 (violating the constraint) → exactly one deferred read starts 4 cycles after each `spi_cs_n` rise, with no lost or duplicated `data_valid` pulse.

Source files
------------

// File: rtl/accel_pkg.sv
// ADXL345 register map, config values and FSM
// encoding shared by the SPI reader slice.
package accel_pkg;

  localparam logic [7:0] ADDR_DATA_FORMAT = 8'h31;
  localparam logic [7:0] ADDR_BW_RATE     = 8'h2C;
  localparam logic [7:0] ADDR_POWER_CTL   = 8'h2D;
  localparam logic [7:0] ADDR_DATAX0      = 8'h32;

  localparam logic [7:0] VAL_DATA_FORMAT  = 8'h04;
  localparam logic [7:0] VAL_BW_RATE      = 8'h0A;
  localparam logic [7:0] VAL_POWER_CTL    = 8'h08;

  localparam int CMD_R_BIT  = 7;
  localparam int CMD_MB_BIT = 6;

  localparam logic [5:0] WR_BITS = 6'd16;

  typedef enum logic [2:0] {
    RESET_WAIT,
    CFG_FMT,
    CFG_RATE,
    CFG_PWR,
    IDLE,
    READ
  } state_e;

  function automatic logic [7:0] burst_rd_cmd(
    input logic [7:0] addr
  );
    logic [7:0] c;
    c = addr;
    c[CMD_R_BIT]  = 1'b1;
    c[CMD_MB_BIT] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/accel_spi_reader_if.sv
// SPI pins plus sample outputs of the
// accelerometer reader, bundled for the top.
interface accel_spi_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  spi_cs_n;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [DATA_WIDTH-1:0] datax0;
  logic [DATA_WIDTH-1:0] datax1;
  logic [DATA_WIDTH-1:0] datay0;
  logic [DATA_WIDTH-1:0] datay1;
  logic                  data_valid;
  logic                  init_done;
  logic                  busy;

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi,
    output datax0, datax1, datay0, datay1,
    output data_valid, init_done, busy,
    input  spi_miso
  );

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi,
    input  datax0, datax1, datay0, datay1,
    input  data_valid, init_done, busy,
    output spi_miso
  );
endinterface

// File: rtl/accel_spi_reader_shift.sv
// Mode-3 SPI shifter: one CS frame of N bits,
// MSB-first TX, MISO shifted into an RX word.
module spi_shift_engine #(
  parameter int CLK_DIV = 25,
  parameter int RXW     = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [5:0]     nbits_i,
  input  logic [15:0]    tx_i,
  input  logic           miso_i,
  output logic           cs_n_o,
  output logic           sclk_o,
  output logic           mosi_o,
  output logic [RXW-1:0] rx_o,
  output logic           done_o
);

  localparam int DW = $clog2(CLK_DIV);

  logic           act_q;
  logic           cs_q;
  logic           sclk_q;
  logic           mosi_q;
  logic [DW-1:0]  div_q;
  logic [6:0]     ph_q;
  logic [6:0]     last_q;
  logic [15:0]    tx_q;
  logic [RXW-1:0] rx_q;
  logic           wrap;
  logic [6:0]     ph_nx;

  // half-period boundary and final phase detect
  always_comb begin
    wrap   = act_q && (div_q == DW'(CLK_DIV - 1));
    ph_nx  = ph_q + 7'd1;
    done_o = wrap && (ph_q == last_q);
  end

  // phase 0 lead-in, odd phases SCLK low,
  // even phases SCLK high, last phase trail-out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      cs_q   <= 1'b1;
      sclk_q <= 1'b1;
      mosi_q <= 1'b0;
      div_q  <= '0;
      ph_q   <= '0;
      last_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
    end else if (!act_q) begin
      if (start_i) begin
        act_q  <= 1'b1;
        cs_q   <= 1'b0;
        sclk_q <= 1'b1;
        mosi_q <= tx_i[15];
        tx_q   <= {tx_i[14:0], 1'b0};
        div_q  <= '0;
        ph_q   <= '0;
        last_q <= {nbits_i, 1'b1};
      end
    end else begin
      div_q <= wrap ? '0 : div_q + DW'(1);
      if (wrap) begin
        ph_q <= ph_nx;
        if (done_o) begin
          act_q  <= 1'b0;
          cs_q   <= 1'b1;
          sclk_q <= 1'b1;
          mosi_q <= 1'b0;
        end else if (ph_nx == last_q) begin
          sclk_q <= 1'b1;
        end else if (ph_nx[0]) begin
          sclk_q <= 1'b0;
          if (ph_nx != 7'd1) begin
            mosi_q <= tx_q[15];
            tx_q   <= {tx_q[14:0], 1'b0};
          end
        end else begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[RXW-2:0], miso_i};
        end
      end
    end
  end

  assign cs_n_o = cs_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL345 configure-then-poll reader: FSM,
// sample timer and glitch-free output bytes.
module accel_spi_reader
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 500000
) (
  input logic               clk,
  input logic               rst_n,
  accel_spi_reader_if.master bus
);

  localparam int GAP = 2 * CLK_DIV;
  localparam int CW  = $clog2(GAP);
  localparam int TW  = $clog2(SAMPLE_PERIOD);
  localparam int RXW = 4 * DATA_WIDTH;
  localparam logic [5:0] RD_BITS = 6'(8 + RXW);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sent_q, sent_d;
  logic                pend_q, pend_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0] x0_q, x1_q, y0_q, y1_q;
  logic                dv_q;
  logic                init_q;

  logic                tick;
  logic                gap_ok;
  logic                start;
  logic                again;
  logic [5:0]          nbits;
  logic [15:0]         tx;
  logic                eng_done;
  logic [RXW-1:0]      rx;
  logic                cs_n;
  logic                sclk;
  logic                mosi;

  assign tick   = tmr_q == TW'(SAMPLE_PERIOD - 1);
  assign gap_ok = cnt_q == CW'(GAP - 1);
  assign again  = pend_q | tick;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESET_WAIT;
    else        state_q <= state_d;
  end

  // next-state: walk the config writes,
  // then alternate IDLE/READ on timer ticks
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET_WAIT: if (gap_ok)   state_d = CFG_FMT;
      CFG_FMT:    if (eng_done) state_d = CFG_RATE;
      CFG_RATE:   if (eng_done) state_d = CFG_PWR;
      CFG_PWR:    if (eng_done) state_d = IDLE;
      IDLE:       if (tick)     state_d = READ;
      READ:       if (eng_done && !again)
                    state_d = IDLE;
      default:    state_d = RESET_WAIT;
    endcase
  end

  // per-state transaction word and launch
  always_comb begin
    tx    = '0;
    nbits = WR_BITS;
    unique case (state_q)
      CFG_FMT:  tx = {ADDR_DATA_FORMAT, VAL_DATA_FORMAT};
      CFG_RATE: tx = {ADDR_BW_RATE, VAL_BW_RATE};
      CFG_PWR:  tx = {ADDR_POWER_CTL, VAL_POWER_CTL};
      READ: begin
        tx    = {burst_rd_cmd(ADDR_DATAX0), 8'h00};
        nbits = RD_BITS;
      end
      default: tx = '0;
    endcase
    start = (state_q inside {CFG_FMT, CFG_RATE, CFG_PWR, READ})
         && !sent_q && gap_ok;
  end

  // gap counter saturates at GAP-1 while CS is
  // high; one tick may queue behind a read
  always_comb begin
    cnt_d  = cnt_q;
    sent_d = sent_q;
    pend_d = pend_q;
    tmr_d  = '0;
    if (!sent_q && !gap_ok) cnt_d = cnt_q + CW'(1);
    if (start) sent_d = 1'b1;
    if (state_q == READ && tick && sent_q) pend_d = 1'b1;
    if (eng_done) begin
      sent_d = 1'b0;
      cnt_d  = '0;
    end
    if (eng_done && state_q == READ) pend_d = 1'b0;
    if (state_q inside {IDLE, READ})
      tmr_d = tick ? '0 : tmr_q + TW'(1);
  end

  // sequencing registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sent_q <= 1'b0;
      pend_q <= 1'b0;
      tmr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sent_q <= sent_d;
      pend_q <= pend_d;
      tmr_q  <= tmr_d;
    end
  end

  // outputs move only on the CS-rise edge of
  // a read, so a sample is never half-updated
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      dv_q   <= 1'b0;
      init_q <= 1'b0;
    end else begin
      dv_q <= eng_done && state_q == READ;
      if (eng_done && state_q == READ) begin
        x0_q <= rx[RXW-1 -: DATA_WIDTH];
        x1_q <= rx[RXW-1-DATA_WIDTH -: DATA_WIDTH];
        y0_q <= rx[2*DATA_WIDTH-1 -: DATA_WIDTH];
        y1_q <= rx[DATA_WIDTH-1:0];
      end
      if (eng_done && state_q == CFG_PWR)
        init_q <= 1'b1;
    end
  end

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV),
    .RXW     (RXW)
  ) u_eng (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .nbits_i (nbits),
    .tx_i    (tx),
    .miso_i  (bus.spi_miso),
    .cs_n_o  (cs_n),
    .sclk_o  (sclk),
    .mosi_o  (mosi),
    .rx_o    (rx),
    .done_o  (eng_done)
  );

  assign bus.spi_cs_n   = cs_n;
  assign bus.spi_sclk   = sclk;
  assign bus.spi_mosi   = mosi;
  assign bus.busy       = ~cs_n;
  assign bus.datax0     = x0_q;
  assign bus.datax1     = x1_q;
  assign bus.datay0     = y0_q;
  assign bus.datay1     = y1_q;
  assign bus.data_valid = dv_q;
  assign bus.init_done  = init_q;

endmodule
